// File: rtl/jtag_pkg.sv
// Shared definitions for the target-side JTAG TAP: state codes, IR opcodes,
// DBGACC op codes and status bit positions.
package jtag_pkg;

  // Standard 1149.1 state encoding, kept as plain constants for legacy tools.
  typedef logic [3:0] tap_state_e;

  localparam tap_state_e TapExit2Dr   = 4'h0;
  localparam tap_state_e TapExit1Dr   = 4'h1;
  localparam tap_state_e TapShiftDr   = 4'h2;
  localparam tap_state_e TapPauseDr   = 4'h3;
  localparam tap_state_e TapSelectIr  = 4'h4;
  localparam tap_state_e TapUpdateDr  = 4'h5;
  localparam tap_state_e TapCaptureDr = 4'h6;
  localparam tap_state_e TapSelectDr  = 4'h7;
  localparam tap_state_e TapExit2Ir   = 4'h8;
  localparam tap_state_e TapExit1Ir   = 4'h9;
  localparam tap_state_e TapShiftIr   = 4'hA;
  localparam tap_state_e TapPauseIr   = 4'hB;
  localparam tap_state_e TapRunIdle   = 4'hC;
  localparam tap_state_e TapUpdateIr  = 4'hD;
  localparam tap_state_e TapCaptureIr = 4'hE;
  localparam tap_state_e TapTlr       = 4'hF;

  // Every opcode other than these two, all-ones included, selects BYPASS.
  localparam int unsigned IrIdcode = 'h01;
  localparam int unsigned IrDbgacc = 'h10;

  localparam logic [1:0] OpNop   = 2'd0;
  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpWrite = 2'd2;
  localparam logic [1:0] OpClear = 2'd3;

  localparam int unsigned StPending = 0;
  localparam int unsigned StSticky  = 1;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller advanced by synchronised tck rises, with decoded
// capture/shift/update strobes for the register logic.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tck_rise_i,
  input  logic       tms_i,
  input  logic       force_tlr_i,
  output tap_state_e state_o,
  output logic       capture_ir_o,
  output logic       shift_ir_o,
  output logic       update_ir_o,
  output logic       capture_dr_o,
  output logic       shift_dr_o,
  output logic       update_dr_o
);

  tap_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (force_tlr_i) begin
      state_d = TapTlr;
    end else if (tck_rise_i) begin
      case (state_q)
        TapTlr:       state_d = tms_i ? TapTlr      : TapRunIdle;
        TapRunIdle:   state_d = tms_i ? TapSelectDr : TapRunIdle;
        TapSelectDr:  state_d = tms_i ? TapSelectIr : TapCaptureDr;
        TapCaptureDr: state_d = tms_i ? TapExit1Dr  : TapShiftDr;
        TapShiftDr:   state_d = tms_i ? TapExit1Dr  : TapShiftDr;
        TapExit1Dr:   state_d = tms_i ? TapUpdateDr : TapPauseDr;
        TapPauseDr:   state_d = tms_i ? TapExit2Dr  : TapPauseDr;
        TapExit2Dr:   state_d = tms_i ? TapUpdateDr : TapShiftDr;
        TapUpdateDr:  state_d = tms_i ? TapSelectDr : TapRunIdle;
        TapSelectIr:  state_d = tms_i ? TapTlr      : TapCaptureIr;
        TapCaptureIr: state_d = tms_i ? TapExit1Ir  : TapShiftIr;
        TapShiftIr:   state_d = tms_i ? TapExit1Ir  : TapShiftIr;
        TapExit1Ir:   state_d = tms_i ? TapUpdateIr : TapPauseIr;
        TapPauseIr:   state_d = tms_i ? TapExit2Ir  : TapPauseIr;
        TapExit2Ir:   state_d = tms_i ? TapUpdateIr : TapShiftIr;
        TapUpdateIr:  state_d = tms_i ? TapSelectDr : TapRunIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TapTlr;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o      = state_q;
  assign capture_ir_o = (state_q == TapCaptureIr);
  assign shift_ir_o   = (state_q == TapShiftIr);
  assign update_ir_o  = (state_q == TapUpdateIr);
  assign capture_dr_o = (state_q == TapCaptureDr);
  assign shift_dr_o   = (state_q == TapShiftDr);
  assign update_dr_o  = (state_q == TapUpdateDr);

endmodule

// File: rtl/jtag_tap_dbg_target.sv
// Target-side JTAG TAP: oversampled pins, IR/DR scan chains and a DBGACC
// register that issues valid/ready requests to the core debug unit.
module jtag_tap_dbg_target
  import jtag_pkg::*;
#(
  parameter int unsigned IR_LEN     = 5,
  parameter logic [31:0] IDCODE_VAL = 32'h1DC0_0001,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jtag_tck,
  input  logic              jtag_tms,
  input  logic              jtag_tdi,
  input  logic              jtag_trstn,
  output logic              jtag_tdo,
  output logic              dbg_req_valid,
  input  logic              dbg_req_ready,
  output logic              dbg_req_write,
  output logic [ADDR_W-1:0] dbg_req_addr,
  output logic [DATA_W-1:0] dbg_req_wdata,
  input  logic              dbg_rsp_valid,
  input  logic [DATA_W-1:0] dbg_rsp_rdata,
  output tap_state_e        tap_state
);

  localparam int unsigned DrW = 2 + ADDR_W + DATA_W;

  logic [1:0] tck_sync_q, tms_sync_q, tdi_sync_q, trstn_sync_q;
  logic       tck_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tck_sync_q   <= '0;
      tms_sync_q   <= '0;
      tdi_sync_q   <= '0;
      trstn_sync_q <= '0;
      tck_prev_q   <= 1'b0;
    end else begin
      tck_sync_q   <= {tck_sync_q[0], jtag_tck};
      tms_sync_q   <= {tms_sync_q[0], jtag_tms};
      tdi_sync_q   <= {tdi_sync_q[0], jtag_tdi};
      trstn_sync_q <= {trstn_sync_q[0], jtag_trstn};
      tck_prev_q   <= tck_sync_q[1];
    end
  end

  logic tck_rise, tck_fall, tdi, force_tlr;
  assign tck_rise  = tck_sync_q[1] & ~tck_prev_q;
  assign tck_fall  = ~tck_sync_q[1] & tck_prev_q;
  assign tdi       = tdi_sync_q[1];
  assign force_tlr = ~trstn_sync_q[1];

  logic capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;

  jtag_tap_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .tck_rise_i   (tck_rise),
    .tms_i        (tms_sync_q[1]),
    .force_tlr_i  (force_tlr),
    .state_o      (tap_state),
    .capture_ir_o (capture_ir),
    .shift_ir_o   (shift_ir),
    .update_ir_o  (update_ir),
    .capture_dr_o (capture_dr),
    .shift_dr_o   (shift_dr),
    .update_dr_o  (update_dr)
  );

  logic [IR_LEN-1:0] ir_q, ir_sr_q;
  logic [31:0]       idcode_sr_q;
  logic              bypass_q, tdo_q;
  logic [DrW-1:0]    dbg_sr_q;

  logic req_valid_q, req_valid_d, req_write_q, req_write_d;
  logic pending_q, pending_d, sticky_q, sticky_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d, last_addr_q, last_addr_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d, last_rdata_q, last_rdata_d;

  logic sel_idcode, sel_dbg, dr_lsb;
  logic [1:0] status;
  assign sel_idcode = (ir_q == IR_LEN'(IrIdcode));
  assign sel_dbg    = (ir_q == IR_LEN'(IrDbgacc));
  assign dr_lsb     = sel_idcode ? idcode_sr_q[0] : (sel_dbg ? dbg_sr_q[0] : bypass_q);

  always_comb begin
    status            = '0;
    status[StPending] = pending_q;
    status[StSticky]  = sticky_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q        <= IR_LEN'(IrIdcode);
      ir_sr_q     <= '0;
      idcode_sr_q <= '0;
      bypass_q    <= 1'b0;
      dbg_sr_q    <= '0;
      tdo_q       <= 1'b0;
    end else begin
      if (tck_rise) begin
        if (capture_ir) begin
          ir_sr_q <= IR_LEN'(1);
        end else if (shift_ir) begin
          ir_sr_q <= {tdi, ir_sr_q[IR_LEN-1:1]};
        end
        if (capture_dr) begin
          idcode_sr_q <= IDCODE_VAL;
          bypass_q    <= 1'b0;
          dbg_sr_q    <= {last_rdata_q, last_addr_q, status};
        end else if (shift_dr) begin
          if (sel_idcode) begin
            idcode_sr_q <= {tdi, idcode_sr_q[31:1]};
          end else if (sel_dbg) begin
            dbg_sr_q <= {tdi, dbg_sr_q[DrW-1:1]};
          end else begin
            bypass_q <= tdi;
          end
        end
      end
      if (force_tlr || tap_state == TapTlr) begin
        ir_q <= IR_LEN'(IrIdcode);
      end else if (tck_fall && update_ir) begin
        ir_q <= ir_sr_q;
      end
      if (tck_fall) begin
        tdo_q <= shift_ir ? ir_sr_q[0] : (shift_dr ? dr_lsb : 1'b0);
      end
    end
  end

  logic       dbg_update;
  logic [1:0] dbg_op;
  assign dbg_update = tck_fall & update_dr & sel_dbg;
  assign dbg_op     = dbg_sr_q[1:0];

  always_comb begin
    req_valid_d  = req_valid_q;
    req_write_d  = req_write_q;
    req_addr_d   = req_addr_q;
    req_wdata_d  = req_wdata_q;
    pending_d    = pending_q;
    sticky_d     = sticky_q;
    last_addr_d  = last_addr_q;
    last_rdata_d = last_rdata_q;
    if (req_valid_q && dbg_req_ready) begin
      req_valid_d = 1'b0;
    end
    if (pending_q && dbg_rsp_valid) begin
      pending_d = 1'b0;
      if (!req_write_q) begin
        last_rdata_d = dbg_rsp_rdata;
      end
    end
    if (dbg_update) begin
      case (dbg_op)
        OpNop: ;
        OpRead, OpWrite: begin
          // A request while one is outstanding is lost; flag it for the host.
          if (pending_q) begin
            sticky_d = 1'b1;
          end else begin
            req_valid_d = 1'b1;
            req_write_d = (dbg_op == OpWrite);
            req_addr_d  = dbg_sr_q[2 +: ADDR_W];
            req_wdata_d = dbg_sr_q[2 + ADDR_W +: DATA_W];
            last_addr_d = dbg_sr_q[2 +: ADDR_W];
            pending_d   = 1'b1;
          end
        end
        OpClear: sticky_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid_q  <= 1'b0;
      req_write_q  <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      pending_q    <= 1'b0;
      sticky_q     <= 1'b0;
      last_addr_q  <= '0;
      last_rdata_q <= '0;
    end else begin
      req_valid_q  <= req_valid_d;
      req_write_q  <= req_write_d;
      req_addr_q   <= req_addr_d;
      req_wdata_q  <= req_wdata_d;
      pending_q    <= pending_d;
      sticky_q     <= sticky_d;
      last_addr_q  <= last_addr_d;
      last_rdata_q <= last_rdata_d;
    end
  end

  assign jtag_tdo      = tdo_q;
  assign dbg_req_valid = req_valid_q;
  assign dbg_req_write = req_write_q;
  assign dbg_req_addr  = req_addr_q;
  assign dbg_req_wdata = req_wdata_q;

endmodule

// File: tb/tb_jtag_tap_dbg_target.sv
// Drives the TAP like a slow JTAG probe and checks state, scan data and debug
// bus traffic against a transaction-level model of the target.
module tb_jtag_tap_dbg_target;

  localparam logic [3:0] StTlr = 4'hF, StRti = 4'hC, StSelDr = 4'h7, StCapDr = 4'h6;
  localparam logic [3:0] StShDr = 4'h2, StEx1Dr = 4'h1, StPauDr = 4'h3, StEx2Dr = 4'h0;
  localparam logic [3:0] StUpdDr = 4'h5, StSelIr = 4'h4, StCapIr = 4'hE, StShIr = 4'hA;
  localparam logic [3:0] StEx1Ir = 4'h9, StPauIr = 4'hB, StEx2Ir = 4'h8, StUpdIr = 4'hD;

  logic        clk = 1'b0, rst = 1'b1;
  logic        jtag_tck = 1'b0, jtag_tms = 1'b1, jtag_tdi = 1'b0, jtag_trstn = 1'b1;
  logic        jtag_tdo;
  logic        dbg_req_valid, dbg_req_write;
  logic        dbg_req_ready = 1'b0, dbg_rsp_valid = 1'b0;
  logic [7:0]  dbg_req_addr;
  logic [31:0] dbg_req_wdata, dbg_rsp_rdata = '0;
  logic [3:0]  tap_state;

  jtag_tap_dbg_target dut (
    .clk           (clk),
    .rst           (rst),
    .jtag_tck      (jtag_tck),
    .jtag_tms      (jtag_tms),
    .jtag_tdi      (jtag_tdi),
    .jtag_trstn    (jtag_trstn),
    .jtag_tdo      (jtag_tdo),
    .dbg_req_valid (dbg_req_valid),
    .dbg_req_ready (dbg_req_ready),
    .dbg_req_write (dbg_req_write),
    .dbg_req_addr  (dbg_req_addr),
    .dbg_req_wdata (dbg_req_wdata),
    .dbg_rsp_valid (dbg_rsp_valid),
    .dbg_rsp_rdata (dbg_rsp_rdata),
    .tap_state     (tap_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Target model: TAP state, IR, and debug-unit status as seen by the host.
  typedef struct packed {
    logic        write;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } req_t;

  logic [3:0]  m_state = StTlr;
  logic [4:0]  m_ir = 5'h01;
  logic        m_pending = 1'b0, m_sticky = 1'b0;
  logic [7:0]  m_last_addr = '0;
  logic [31:0] m_last_rdata = '0;
  req_t        exp_q[$];

  int          ready_delay = 2, wait_cnt = 0, last_valid_len = 0, n_accepted = 0;
  bit          rsp_hold = 1'b0, rsp_due = 1'b0, rsp_is_write = 1'b0;
  logic [31:0] rsp_data = '0;

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    case (s)
      StTlr:   return tms ? StTlr   : StRti;
      StRti:   return tms ? StSelDr : StRti;
      StSelDr: return tms ? StSelIr : StCapDr;
      StCapDr: return tms ? StEx1Dr : StShDr;
      StShDr:  return tms ? StEx1Dr : StShDr;
      StEx1Dr: return tms ? StUpdDr : StPauDr;
      StPauDr: return tms ? StEx2Dr : StPauDr;
      StEx2Dr: return tms ? StUpdDr : StShDr;
      StUpdDr: return tms ? StSelDr : StRti;
      StSelIr: return tms ? StTlr   : StCapIr;
      StCapIr: return tms ? StEx1Ir : StShIr;
      StShIr:  return tms ? StEx1Ir : StShIr;
      StEx1Ir: return tms ? StUpdIr : StPauIr;
      StPauIr: return tms ? StEx2Ir : StPauIr;
      StEx2Ir: return tms ? StUpdIr : StShIr;
      default: return tms ? StSelDr : StRti;
    endcase
  endfunction

  function automatic logic [63:0] dbg_cmd(input logic [1:0] op, input logic [7:0] addr,
                                          input logic [31:0] data);
    return {22'b0, data, addr, op};
  endfunction

  task automatic model_dbg_update(input logic [41:0] cmd);
    req_t r;
    if (cmd[1:0] == 2'd1 || cmd[1:0] == 2'd2) begin
      if (m_pending) begin
        m_sticky = 1'b1;
      end else begin
        r.write = (cmd[1:0] == 2'd2);
        r.addr  = cmd[9:2];
        r.wdata = cmd[41:10];
        exp_q.push_back(r);
        m_pending   = 1'b1;
        m_last_addr = cmd[9:2];
      end
    end else if (cmd[1:0] == 2'd3) begin
      m_sticky = 1'b0;
    end
  endtask

  // One tck period; tdo is sampled just before the rising edge.
  task automatic step(input logic tms, input logic tdi, output logic tdo_s);
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (3) @(negedge clk);
    tdo_s    = jtag_tdo;
    jtag_tck = 1'b1;
    m_state  = tap_next(m_state, tms);
    repeat (5) @(negedge clk);
    check("tap_state", 64'(tap_state), 64'(m_state));
    jtag_tck = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic scan(input bit is_ir, input int n, input logic [63:0] din,
                      output logic [63:0] dout);
    logic b;
    dout = '0;
    step(1'b1, 1'b0, b);
    if (is_ir) step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], b);
      dout[i] = b;
    end
    if (is_ir) m_ir = din[4:0];
    else if (m_ir == 5'h10) model_dbg_update(din[41:0]);
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
  endtask

  task automatic ir_scan(input logic [4:0] v);
    logic [63:0] d;
    scan(1'b1, 5, 64'(v), d);
    check("ir_capture", d, 64'h1);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic [63:0] cap, exp;
    int w;
    if (m_ir == 5'h01) begin
      cap = 64'h1DC0_0001;
      w   = 32;
    end else if (m_ir == 5'h10) begin
      cap = {22'b0, m_last_rdata, m_last_addr, m_sticky, m_pending};
      w   = 42;
    end else begin
      cap = '0;
      w   = 1;
    end
    exp = '0;
    for (int i = 0; i < n; i++) exp[i] = (i < w) ? cap[i] : din[i - w];
    scan(1'b0, n, din, dout);
    check("dr_out", dout, exp);
  endtask

  // Debug-unit responder and per-cycle bus checker.
  initial begin : responder
    forever begin
      @(negedge clk);
      dbg_rsp_valid = 1'b0;
      if (rsp_due && !rsp_hold) begin
        dbg_rsp_valid = 1'b1;
        dbg_rsp_rdata = rsp_data;
        rsp_due       = 1'b0;
        if (m_pending) begin
          m_pending = 1'b0;
          if (!rsp_is_write) m_last_rdata = rsp_data;
        end
      end
      dbg_req_ready = 1'b0;
      if (rst) begin
        wait_cnt = 0;
      end else if (dbg_req_valid) begin
        wait_cnt++;
        if (exp_q.size() == 0) begin
          check("req_unexpected", 64'(dbg_req_valid), 64'h0);
        end else begin
          check("req_write", 64'(dbg_req_write), 64'(exp_q[0].write));
          check("req_addr", 64'(dbg_req_addr), 64'(exp_q[0].addr));
          check("req_wdata", 64'(dbg_req_wdata), 64'(exp_q[0].wdata));
          if (wait_cnt > ready_delay) begin
            dbg_req_ready  = 1'b1;
            last_valid_len = wait_cnt;
            wait_cnt       = 0;
            rsp_due        = 1'b1;
            rsp_is_write   = dbg_req_write;
            void'(exp_q.pop_front());
            n_accepted++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not finish, %0d checks so far", n_checks);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [63:0] d;
    logic b;
    repeat (4) @(negedge clk);
    check("rst_state", 64'(tap_state), 64'hF);
    check("rst_tdo", 64'(jtag_tdo), 64'h0);
    check("rst_valid", 64'(dbg_req_valid), 64'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    check("rti_literal", 64'(tap_state), 64'hC);

    dr_scan(32, 64'h0, d);
    check("idcode_literal", 64'(d[31:0]), 64'h1DC0_0001);

    ir_scan(5'h1F);
    dr_scan(8, 64'hA5, d);
    check("bypass_literal", 64'(d[7:0]), 64'h4A);

    ir_scan(5'h10);
    rsp_data = 32'h0BAD_F00D;
    dr_scan(42, dbg_cmd(2'd2, 8'h04, 32'hDEAD_BEEF), d);
    dr_scan(42, dbg_cmd(2'd0, 8'h00, 32'h0), d);
    check("write_valid_len", 64'(last_valid_len), 64'd3);
    check("status_after_write", 64'(d[1:0]), 64'h0);
    check("last_addr_write", 64'(d[9:2]), 64'h04);

    rsp_data = 32'h1234_5678;
    dr_scan(42, dbg_cmd(2'd1, 8'h10, 32'h0), d);
    dr_scan(42, dbg_cmd(2'd0, 8'h00, 32'h0), d);
    check("read_rdata_literal", 64'(d[41:10]), 64'h1234_5678);
    check("read_addr_literal", 64'(d[9:2]), 64'h10);

    rsp_hold = 1'b1;
    rsp_data = 32'hFFFF_0000;
    dr_scan(42, dbg_cmd(2'd2, 8'h20, 32'h1111_1111), d);
    dr_scan(42, dbg_cmd(2'd2, 8'h30, 32'h2222_2222), d);
    dr_scan(42, dbg_cmd(2'd3, 8'h00, 32'h0), d);
    check("overrun_status", 64'(d[1:0]), 64'h3);
    dr_scan(42, dbg_cmd(2'd0, 8'h00, 32'h0), d);
    check("clear_status", 64'(d[1:0]), 64'h1);

    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, b);
    jtag_trstn = 1'b0;
    m_state    = StTlr;
    m_ir       = 5'h01;
    repeat (8) @(negedge clk);
    check("trst_state", 64'(tap_state), 64'hF);
    jtag_trstn = 1'b1;
    repeat (6) @(negedge clk);
    check("trst_no_req", 64'(dbg_req_valid), 64'h0);
    rsp_hold = 1'b0;
    repeat (6) @(negedge clk);
    step(1'b0, 1'b0, b);
    dr_scan(32, 64'h0, d);
    check("trst_idcode", 64'(d[31:0]), 64'h1DC0_0001);
    ir_scan(5'h10);
    dr_scan(42, dbg_cmd(2'd0, 8'h00, 32'h0), d);
    check("trst_status", 64'(d[1:0]), 64'h0);
    check("trst_rdata_kept", 64'(d[41:10]), 64'h1234_5678);
    check("trst_last_addr", 64'(d[9:2]), 64'h20);

    check("n_accepted", 64'(n_accepted), 64'd3);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
